// File: rtl/fb_pixel_writer_pkg.sv
// fb_pixel_writer_pkg
//   Shared definitions for the frame-buffer write path. These are the same
//   screen geometry and pixel layout that the VGA scan-out unit reads back.
//   - Default screen geometry and Avalon address width.
//   - Write-side FSM state type.
//   - Default pixel FIFO entry: a precomputed byte address plus a colour word.
//   - row_base(): pixel index of the first pixel on a line.
package fb_pixel_writer_pkg;

    localparam int FB_H_RES         = 640;
    localparam int FB_V_RES         = 480;
    localparam int FB_ADDR_W        = 26;
    localparam int BYTES_PER_PIXEL  = 4;
    localparam int FRAME_WORDS      = FB_H_RES * FB_V_RES;
    localparam int PIX_SHIFT        = $clog2(BYTES_PER_PIXEL);

    typedef enum logic [1:0] {
        IDLE,
        PIX_WR,
        CLEAR_WR
    } fbw_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [31:0]          data;
    } pix_entry_t;

    // y * h_res. At the native 640-pixel width this is two shifted adds,
    // (y << 9) + (y << 7), so no hard multiplier is needed. Other widths
    // fall back to a constant multiply.
    function automatic logic [31:0] row_base(input logic [9:0] y, input int h_res);
        logic [31:0] y32;
        y32 = {22'd0, y};
        if (h_res == 640) begin
            return (y32 << 9) + (y32 << 7);
        end
        return y32 * 32'(h_res);
    endfunction

endpackage

// File: rtl/fb_pixel_writer_pix_fifo.sv
// pix_fifo
//   A synchronous show-ahead FIFO that holds pending pixel writes.
//   dout always shows the head entry while empty is low.
//   A push is ignored when the FIFO is full, and a pop is ignored when it is
//   empty. As a result, the FIFO can neither overflow nor underflow.
//   Ports:
//     clk, reset  clock and asynchronous active-low reset
//     push, din   write din at the tail
//     pop         drop the head entry
//     dout        head entry
//     full, empty occupancy flags
module pix_fifo
    import fb_pixel_writer_pkg::*;
#(
    parameter type T     = pix_entry_t,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The storage holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   This is the write side of the frame buffer. It accepts (x, y, colour)
//   pixel writes, queues them, and issues single-word Avalon-MM writes into
//   the back buffer. It can also fill the whole screen with one colour.
//   Ports:
//     clk, reset                   clock and asynchronous active-low reset
//     back_buffer_ptr              byte base of the buffer being drawn
//     pix_valid/pix_ready          pixel handshake; a pixel is taken when both are high
//     pix_x, pix_y, pix_color      pixel position and word
//     clear_req, clear_color       one-cycle request to fill the buffer
//     clear_done                   one-cycle pulse after the last fill write
//     busy                         work queued or in progress
//     master_*                     Avalon-MM write master (32-bit, byteenable F)
//   Handshake: the pixel port transfers on any cycle where pix_valid and
//   pix_ready are both high. The Avalon master holds address, data and write
//   stable while master_waitrequest is high. A write completes on the cycle
//   where master_write is high and master_waitrequest is low.
module fb_pixel_writer
    import fb_pixel_writer_pkg::*;
#(
    parameter int H_RES      = FB_H_RES,
    parameter int V_RES      = FB_V_RES,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] back_buffer_ptr,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [31:0]       pix_color,
    input  logic              clear_req,
    input  logic [31:0]       clear_color,
    output logic              clear_done,
    output logic              busy,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    output logic [3:0]        master_byteenable,
    input  logic              master_waitrequest
);

    localparam int              SCREEN_WORDS = H_RES * V_RES;
    localparam int              CNT_W        = $clog2(SCREEN_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(SCREEN_WORDS - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    fbw_state_t        state;
    logic              clear_pending;
    logic [31:0]       clear_color_q;
    logic [ADDR_W-1:0] clear_base;
    logic [CNT_W-1:0]  clear_cnt;
    logic [CNT_W-1:0]  clear_cnt_next;
    logic [ADDR_W-1:0] clear_addr_next;

    entry_t            push_entry;
    entry_t            head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              in_range;
    logic              clear_accept;
    logic [31:0]       pix_index;

    // The address is resolved at accept time. A later buffer swap therefore
    // cannot redirect pixels that are already queued.
    always_comb begin
        in_range        = ({22'd0, pix_x} < 32'(H_RES)) && ({22'd0, pix_y} < 32'(V_RES));
        pix_index       = row_base(pix_y, H_RES) + {22'd0, pix_x};
        push_entry.addr = back_buffer_ptr + ADDR_W'(pix_index << PIX_SHIFT);
        push_entry.data = pix_color;
    end

    // Gating pix_ready with reset keeps the port closed while reset is held.
    assign pix_ready         = reset & ~fifo_full & ~clear_pending & (state != CLEAR_WR);
    // Out-of-range pixels complete the handshake but are never queued.
    assign fifo_push         = pix_valid & pix_ready & in_range;
    assign clear_accept      = clear_req & ~clear_pending & (state != CLEAR_WR);
    assign busy              = ~fifo_empty | master_write | clear_pending | (state != IDLE);
    assign master_byteenable = 4'hF;

    assign clear_cnt_next  = clear_cnt + 1'b1;
    assign clear_addr_next = clear_base + ADDR_W'({{(32-CNT_W){1'b0}}, clear_cnt_next} << PIX_SHIFT);

    // Pop when a new bus write can be loaded. In IDLE, a pending clear only
    // takes over once the FIFO is empty, so queued pixels drain first. In
    // PIX_WR, a pending clear stops back-to-back streaming, and the rest of
    // the FIFO drains through IDLE.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = ~fifo_empty;
            PIX_WR:  fifo_pop = ~master_waitrequest & ~fifo_empty & ~clear_pending;
            default: fifo_pop = 1'b0;
        endcase
    end

    pix_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            clear_pending    <= 1'b0;
            clear_color_q    <= '0;
            clear_base       <= '0;
            clear_cnt        <= '0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            clear_done       <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (clear_accept) begin
                clear_pending <= 1'b1;
                clear_color_q <= clear_color;
            end
            case (state)
                IDLE: begin
                    if (clear_pending && fifo_empty) begin
                        state            <= CLEAR_WR;
                        clear_pending    <= 1'b0;
                        clear_base       <= back_buffer_ptr;
                        clear_cnt        <= '0;
                        master_address   <= back_buffer_ptr;
                        master_writedata <= clear_color_q;
                        master_write     <= 1'b1;
                    end else if (fifo_pop) begin
                        state            <= PIX_WR;
                        master_address   <= head_entry.addr;
                        master_writedata <= head_entry.data;
                        master_write     <= 1'b1;
                    end
                end
                PIX_WR: begin
                    if (!master_waitrequest) begin
                        if (fifo_pop) begin
                            master_address   <= head_entry.addr;
                            master_writedata <= head_entry.data;
                        end else begin
                            state        <= IDLE;
                            master_write <= 1'b0;
                        end
                    end
                end
                CLEAR_WR: begin
                    if (!master_waitrequest) begin
                        if (clear_cnt == LAST_WORD) begin
                            state        <= IDLE;
                            master_write <= 1'b0;
                            clear_done   <= 1'b1;
                        end else begin
                            clear_cnt      <= clear_cnt_next;
                            master_address <= clear_addr_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer
//   Directed and randomized checks of fb_pixel_writer. The screen is reduced
//   to 640x16 so that a full clear stays short; the 640-wide line stride is
//   kept. Expected bus writes come from a reference model written straight
//   from the address rule base + (y*H_RES + x)*4, and are queued in push order.
module tb_fb_pixel_writer;

    localparam int H_RES      = 640;
    localparam int V_RES      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 26;
    localparam int FRAME      = H_RES * V_RES;
    localparam int W          = 64;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] back_buffer_ptr = '0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [9:0]        pix_x = '0;
    logic [9:0]        pix_y = '0;
    logic [31:0]       pix_color = '0;
    logic              clear_req = 1'b0;
    logic [31:0]       clear_color = '0;
    logic              clear_done;
    logic              busy;
    logic [ADDR_W-1:0] master_address;
    logic              master_write;
    logic [31:0]       master_writedata;
    logic [3:0]        master_byteenable;
    logic              master_waitrequest = 1'b0;

    fb_pixel_writer #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .back_buffer_ptr    (back_buffer_ptr),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_x              (pix_x),
        .pix_y              (pix_y),
        .pix_color          (pix_color),
        .clear_req          (clear_req),
        .clear_color        (clear_color),
        .clear_done         (clear_done),
        .busy               (busy),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_byteenable  (master_byteenable),
        .master_waitrequest (master_waitrequest)
    );

    // waitrequest source: 0 = never stall, 1 = always stall, 2 = random 25 %
    int wait_mode = 0;
    always @(posedge clk) begin
        #1;
        case (wait_mode)
            0:       master_waitrequest = 1'b0;
            1:       master_waitrequest = 1'b1;
            default: master_waitrequest = ($urandom_range(0, 3) == 0);
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      obs_q[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                done_pulses = 0;
    int                writes_at_done = 0;
    int                ready_viol = 0;
    int                stab_viol = 0;
    int                be_viol = 0;
    bit                watch_ready = 1'b0;
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]       prev_data = '0;

    // Bus monitor: records every completed write, and counts protocol slips.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(master_write && master_address == prev_addr &&
                                master_writedata == prev_data))
                stab_viol++;
            if (master_write && master_byteenable != 4'hF) be_viol++;
            if (master_write && !master_waitrequest)
                obs_q.push_back({6'd0, master_address, master_writedata});
            if (clear_done) begin
                done_pulses++;
                writes_at_done = obs_q.size();
            end else if (watch_ready && pix_ready) begin
                ready_viol++;
            end
            prev_stall = master_write && master_waitrequest;
            prev_addr  = master_address;
            prev_data  = master_writedata;
        end
    end

    function automatic logic [W-1:0] model_entry(input logic [ADDR_W-1:0] base,
                                                  input int x, input int y,
                                                  input logic [31:0] c);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(32'(base) + 32'((y * H_RES + x) * 4));
        return {6'd0, a, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        int bad;
        int n_obs;
        int n_exp;
        logic [W-1:0] e;
        logic [W-1:0] o;
        bad   = 0;
        n_obs = obs_q.size();
        n_exp = exp_q.size();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e) bad++;
        end
        check({tag, "_nwrites"}, 64'(n_obs), 64'(n_exp));
        check({tag, "_order_data"}, 64'(bad), 64'd0);
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pix(input int x, input int y, input logic [31:0] c,
                            input int budget, output bit ok);
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_color = c;
        pix_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (x < H_RES && y < V_RES) exp_q.push_back(model_entry(back_buffer_ptr, x, y, c));
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (!busy) break;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit           ok;
        int           first_refused;
        int           n_bad_accept;
        int           done_before;
        int           x;
        int           y;
        logic [W-1:0] hold_exp;

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #2;
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write", 64'(master_write), 64'd0);
        check("rst_address", 64'(master_address), 64'd0);
        check("rst_writedata", 64'(master_writedata), 64'd0);
        check("rst_clear_done", 64'(clear_done), 64'd0);
        check("byteenable", 64'(master_byteenable), 64'hF);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        check("idle_pix_ready", 64'(pix_ready), 64'd1);

        // Single pixel
        back_buffer_ptr = 26'h100000;
        send_pix(3, 2, 32'hDEADBEEF, 50, ok);
        check("s1_accept", 64'(ok), 64'd1);
        wait_idle("s1_idle", 100);
        check("s1_nwrites", 64'(obs_q.size()), 64'd1);
        check("s1_word", (obs_q.size() > 0) ? obs_q[0] : 64'd0,
              {6'd0, 26'h10140C, 32'hDEADBEEF});
        exp_q.delete();
        obs_q.delete();

        // Single pixel held by waitrequest for 3 cycles
        wait_mode = 1;
        hold_exp  = model_entry(back_buffer_ptr, 10, 5, 32'h0BADF00D);
        send_pix(10, 5, 32'h0BADF00D, 50, ok);
        for (int i = 0; i < 20; i++) begin
            if (master_write) break;
            @(posedge clk);
            #2;
        end
        for (int k = 0; k < 3; k++) begin
            check("s3_hold_write", 64'(master_write), 64'd1);
            check("s3_hold_word", {6'd0, master_address, master_writedata}, hold_exp);
            if (k < 2) begin
                @(posedge clk);
                #2;
            end
        end
        wait_mode = 0;
        wait_idle("s3_idle", 100);
        check_writes("s3");

        // 10 pixels against a stuck waitrequest: 8 queued plus 1 on the bus
        wait_mode     = 1;
        first_refused = -1;
        for (int i = 0; i < 10; i++) begin
            send_pix(i * 7, i % V_RES, 32'hC0DE0000 + 32'(i), 20, ok);
            if (!ok) begin
                if (first_refused < 0) first_refused = i;
                wait_mode = 0;
                send_pix(i * 7, i % V_RES, 32'hC0DE0000 + 32'(i), 200, ok);
            end
        end
        check("s4_refused_at", 64'(first_refused), 64'd9);
        wait_idle("s4_idle", 200);
        check_writes("s4");

        // Out-of-range pixels are accepted and dropped
        send_pix(640, 0, 32'h11111111, 50, ok);
        check("s5_oor_x_accept", 64'(ok), 64'd1);
        check("s5_oor_x_busy", 64'(busy), 64'd0);
        send_pix(0, V_RES, 32'h22222222, 50, ok);
        check("s5_oor_y_accept", 64'(ok), 64'd1);
        send_pix(0, 480, 32'h33333333, 50, ok);
        check("s5_oor_480_accept", 64'(ok), 64'd1);
        check("s5_oor_480_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #2;
        check_writes("s5");

        // Random pixels, random stalls, random buffer swaps
        wait_mode    = 2;
        n_bad_accept = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                back_buffer_ptr = ADDR_W'($urandom_range(0, 63)) << 20;
            x = $urandom_range(0, H_RES + 15);
            y = $urandom_range(0, V_RES + 1);
            send_pix(x, y, $urandom, 500, ok);
            if (!ok) n_bad_accept++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        check("s6_accepts", 64'(n_bad_accept), 64'd0);
        wait_idle("s6_idle", 2000);
        check_writes("s6");

        // Drain-then-clear. The second pixel shares its cycle with clear_req,
        // and a repeated clear_req with another colour must be ignored.
        wait_mode       = 1;
        back_buffer_ptr = 26'h100000;
        send_pix(5, 1, 32'hAAAA0001, 50, ok);
        clear_color = 32'h00000000;
        clear_req   = 1'b1;
        send_pix(6, 1, 32'hAAAA0002, 50, ok);
        clear_color = 32'h12345678;
        @(posedge clk);
        #1;
        clear_req       = 1'b0;
        watch_ready     = 1'b1;
        back_buffer_ptr = 26'h200000;
        for (int k = 0; k < FRAME; k++)
            exp_q.push_back({6'd0, ADDR_W'(32'h200000 + 32'(k * 4)), 32'h0});
        wait_mode = 2;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            #2;
            if (done_pulses > 0) break;
        end
        watch_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("s7_done_pulses", 64'(done_pulses), 64'd1);
        check("s7_writes_at_done", 64'(writes_at_done), 64'(FRAME + 2));
        check("s7_ready_low", 64'(ready_viol), 64'd0);
        check("s7_busy", 64'(busy), 64'd0);
        check_writes("s7");

        // Reset in the middle of a clear
        done_before     = done_pulses;
        wait_mode       = 0;
        back_buffer_ptr = 26'h300000;
        clear_color     = 32'hA5A5A5A5;
        clear_req       = 1'b1;
        @(posedge clk);
        #2;
        clear_req = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #2;
            if (obs_q.size() >= 1000) break;
        end
        check("s8_reached_1000", 64'(obs_q.size() >= 1000), 64'd1);
        reset = 1'b0;
        #1;
        check("s8_rst_write", 64'(master_write), 64'd0);
        check("s8_rst_address", 64'(master_address), 64'd0);
        check("s8_rst_writedata", 64'(master_writedata), 64'd0);
        check("s8_rst_busy", 64'(busy), 64'd0);
        check("s8_rst_pix_ready", 64'(pix_ready), 64'd0);
        check("s8_rst_clear_done", 64'(clear_done), 64'd0);
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2;
        check("s8_post_busy", 64'(busy), 64'd0);
        check("s8_post_pix_ready", 64'(pix_ready), 64'd1);
        send_pix(639, 15, 32'h5EED5EED, 50, ok);
        check("s8_post_accept", 64'(ok), 64'd1);
        wait_idle("s8_post_idle", 100);
        check_writes("s8");
        check("s8_no_done", 64'(done_pulses), 64'(done_before));

        // Bus protocol over the whole run
        check("avalon_hold_stable", 64'(stab_viol), 64'd0);
        check("avalon_byteenable", 64'(be_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Upstream neighbour of the VGA scan-out unit: the write side of the frame buffer.
- Accepts (x, y, color) pixel writes from the rasterizer through a ready/valid port, buffers them in a small FIFO, and issues single-word Avalon-MM writes into the back buffer in SDRAM.
- Also performs a full-screen clear on request.
- Pixels are 32-bit words at base + (y*H_RES + x)*4, the layout the scan-out unit reads.

Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- FIFO_DEPTH, 8, pixel FIFO entries (power of two)
- ADDR_W, 26, Avalon byte-address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- back_buffer_ptr  in  ADDR_W  byte base of the buffer being drawn
- pix_valid  in  1  pixel write request
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- pix_x  in  10  pixel column
- pix_y  in  10  pixel row
- pix_color  in  32  pixel word
- clear_req  in  1  one-cycle pulse: fill the buffer with clear_color
- clear_color  in  32  fill word, sampled with clear_req
- clear_done  out  1  one-cycle pulse after the last clear write is accepted
- busy  out  1  FIFO non-empty, a write is pending, or a clear is pending or active
- master_address  out  ADDR_W  Avalon write address
- master_write  out  1  Avalon write strobe
- master_writedata  out  32  Avalon write data
- master_byteenable  out  4  always 4'hF
- master_waitrequest  in  1  Avalon stall

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty; state IDLE; clear_pending 0.
  - master_write 0, master_address 0, master_writedata 0.
  - clear_done 0, busy 0, pix_ready 0 while reset is asserted.
- Push side:
  - pix_ready = !fifo_full & !clear_pending & (state != CLEAR).
  - On accept, the address is computed immediately: back_buffer_ptr + ((pix_y*H_RES + pix_x) << 2), truncated to ADDR_W.
  - The address and pix_color are pushed together. A buffer swap therefore never redirects already-accepted pixels.
  - Out of range (pix_x >= H_RES or pix_y >= V_RES): the pixel is accepted (handshake completes) but discarded, never pushed.
- States:
  - IDLE:
    - if clear_pending & fifo_empty -> CLEAR_WR; latch base = back_buffer_ptr, count = 0, clear_pending 0.
    - else if !fifo_empty -> pop the head into the output registers, master_write 1 -> PIX_WR.
  - PIX_WR:
    - hold address/data/write stable while master_waitrequest is 1.
    - When waitrequest is 0, the write completes that cycle. Then, if !fifo_empty and no clear is pending, pop the next entry with master_write staying 1 (back-to-back, one word per cycle at zero wait). Otherwise -> IDLE with master_write 0.
  - CLEAR_WR:
    - master_address = base + (count << 2), data = latched clear_color, master_write 1.
    - On each accepted write (waitrequest 0), count increments.
    - When count = H_RES*V_RES-1 is accepted -> IDLE; clear_done pulses the following cycle.
- clear_req:
  - Sets clear_pending and latches clear_color.
  - Pixels accepted before it are written first (drain-then-clear ordering).
  - clear_req while pending or clearing is ignored.
  - clear_req in the same cycle as a pixel accept: the pixel is accepted and precedes the clear.
- FIFO boundaries:
  - Push and pop in the same cycle when full: the push is refused (pix_ready is already 0). No overflow or underflow is possible.
  - Simultaneous push and pop at count 1: count stays 1.
- Avalon rules: master_address and master_writedata never change while master_write & master_waitrequest.
- Reset mid-write: the write is abandoned, with no completion required. Software re-issues a clear.

Decomposition:
- vga_pkg:
  - H_RES, V_RES, BYTES_PER_PIXEL = 4.
  - FRAME_WORDS = H_RES*V_RES.
  - typedef enum {IDLE, PIX_WR, CLEAR_WR} fbw_state_t.
  - typedef struct {addr[ADDR_W], data[32]} pix_entry_t.
- Sub-module pix_fifo:
  - synchronous, FIFO_DEPTH x pix_entry_t, show-ahead.
  - ports: push, pop, full, empty, din, dout.
- Address multiply in the top level: y*640 = (y<<9)+(y<<7), no hard multiplier.

Test Plan:
- Single pixel, base 0x100000, x=3, y=2, color 0xDEADBEEF -> one write to 0x10140C with data 0xDEADBEEF, byteenable F; busy back to 0 after completion.
- Same write with waitrequest high for 3 cycles -> address and data held 4 cycles, exactly one write counted.
- Push 10 pixels with waitrequest stuck at 1 -> pix_ready drops after 8 accepts (plus one in flight). Release waitrequest -> all 10 written in push order, no loss or duplication.
- x=640, y=0 and x=0, y=480 -> handshake completes, no bus write, busy never stays set.
- 2 pixels queued, then clear_req with color 0x00000000, base 0x200000 -> both pixels written first, then 307200 writes from 0x200000 to 0x32BFFC, then clear_done for exactly one cycle. pix_ready is 0 throughout the clear.
- Assert reset mid-clear at count 1000 -> outputs are at reset values immediately. After release: idle, FIFO empty, new pixel writes work normally.
